slc3_mem_bridge: RTL
====================

SLC3_MEM_BRIDGE -- requirements
Module: slc3_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: MAR and BRAM address width.
REQ-002 SHALL have parameter RD_LAT, default 2: BRAM read latency in cycles (synchronous array plus output register).
REQ-003 SHALL have parameter IO_ADDR, default 16'hFFFF: memory-mapped I/O address.
REQ-004 Reset is Reset, synchronous, active-high; clock is Clk.
REQ-005 Ports, one per line (name, direction, width, meaning):
 Clk  in  1  clock
 Reset  in  1  sync active-high reset
 LD_MAR  in  1  load MAR from Bus
 LD_MDR  in  1  load MDR
 Mem_OE  in  1  read request, level, from control unit
 Mem_WE  in  1  write request, level, from control unit
 Bus  in  16  datapath bus
 SW  in  16  board switches, asynchronous
 MAR  out  16  memory address register
 MDR  out  16  memory data register
 bram_addr  out  ADDR_W  BRAM address
 bram_wdata  out  16  BRAM write data
 bram_we  out  1  BRAM write strobe
 bram_rdata  in  16  BRAM read data, valid RD_LAT cycles after address
 Mem_Ready  out  1  read data valid or write committed
 HEX_DATA  out  16  hex display register

Function
REQ-006 SHALL load MAR <= Bus on any cycle with LD_MAR=1.
REQ-007 SHALL drive bram_addr = MAR and bram_wdata = MDR combinationally.
REQ-008 FSM states SHALL be IDLE, RD_WAIT, RD_DONE, WR_DONE.
REQ-009 IDLE: Mem_WE=1 -> WR_DONE; else Mem_OE=1 -> RD_WAIT with latency counter cleared; else stay.
REQ-010 RD_WAIT SHALL increment its counter each cycle and go to RD_DONE when the counter reaches RD_LAT-1; Mem_OE dropping before then -> IDLE.
REQ-011 RD_DONE SHALL assert Mem_Ready; it SHALL stay while Mem_OE=1 and return to IDLE when Mem_OE=0.
REQ-012 Read data SHALL be SW_sync when MAR==IO_ADDR, else bram_rdata.
REQ-013 bram_we SHALL be a single-cycle pulse on the IDLE->WR_DONE cycle, never repeated while Mem_WE stays high.
REQ-014 WR_DONE SHALL assert Mem_Ready and stay until Mem_WE=0, then go to IDLE.
REQ-015 Mem_WE and Mem_OE both high SHALL be treated as a write (write priority).
REQ-016 LD_MDR=1 with Mem_OE=1 and Mem_WE=0 SHALL load MDR <= read data; LD_MDR=1 otherwise SHALL load MDR <= Bus.
REQ-017 LD_MDR with Mem_OE in a non-RD_DONE state SHALL still load the current read-data mux value (no stall; the control unit guarantees timing).
REQ-018 SW SHALL pass through a two-flop synchronizer (SW_sync) before any use.
REQ-019 A write with MAR==IO_ADDR SHALL update HEX_DATA <= MDR and SHALL NOT pulse bram_we.
REQ-020 MAR changes during RD_WAIT are illegal; bridge behaviour is then don't-care but SHALL return to IDLE when Mem_OE drops.

Reset
REQ-021 Reset SHALL force state IDLE, counter 0, MAR=0, MDR=0, HEX_DATA=0, SW synchronizer=0, bram_we=0, Mem_Ready=0.
REQ-022 Reset during RD_WAIT or WR_DONE SHALL abort the access with no further bram_we pulse.

Configuration
REQ-023 Macro SLC3_MMIO_EN: when defined, REQ-012/REQ-019 I/O decode is active; when undefined, IO_ADDR is ordinary memory, HEX_DATA is tied to 0, and SW is unused.

Structure
REQ-024 Shared package slc3_pkg SHALL hold the FSM state enum, IO_ADDR default and the 16-bit word typedef.
REQ-025 The two-flop synchronizer SHALL be a sub-module named sync2 (16 bits wide), instantiated once.

Verification
REQ-026 MAR=0x0010, BRAM[0x10]=0x1234, Mem_OE held 3 cycles, LD_MDR on 3rd -> Mem_Ready on 3rd cycle, MDR=0x1234.
REQ-027 MDR=0xBEEF, MAR=0x0020, Mem_WE+Mem_OE held 3 cycles -> exactly one bram_we pulse, BRAM[0x20]=0xBEEF.
REQ-028 SW=0x00A5, MAR=0xFFFF, read -> MDR=0x00A5 (MMIO on); with the macro off -> MDR=BRAM[0xFFFF].
REQ-029 MDR=0x0042, MAR=0xFFFF, write -> HEX_DATA=0x0042, no bram_we.
REQ-030 Reset asserted in RD_WAIT -> next cycle state IDLE, Mem_Ready=0, MAR=0, MDR=0.
REQ-031 LD_MDR with Mem_OE=0, Bus=0x7777 -> MDR=0x7777, FSM stays IDLE.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 memory bridge.
// Holds the bridge FSM state encoding, the 16-bit machine word type and the
// default memory-mapped I/O address.
package slc3_pkg;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2,
      WR_DONE = 2'd3
   } bridge_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   d_i        : asynchronous input vector
//   q_o        : synchronized output, two Clk cycles behind d_i
module sync2 #(
   parameter int unsigned W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // First stage may go metastable; only the second stage is consumed.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory bridge: MAR/MDR registers, BRAM handshake FSM and optional
// memory-mapped I/O (switches in, hex display out).
// Build option: define SLC3_MMIO_EN to decode IO_ADDR as I/O; otherwise
// IO_ADDR is plain memory, HEX_DATA reads 0 and SW is ignored.
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   LD_MAR, LD_MDR    : register load strobes from control unit
//   Mem_OE, Mem_WE    : level read / write requests (write wins)
//   Bus               : datapath bus
//   SW                : asynchronous board switches
//   MAR, MDR          : address / data registers
//   bram_addr/wdata/we: BRAM write-side controls, bram_rdata read data
//   Mem_Ready         : read data valid or write committed
//   HEX_DATA          : hex display register
module slc3_mem_bridge
   import slc3_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned RD_LAT  = 2,
   parameter word_t       IO_ADDR = IO_ADDR_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       Bus,
   input  logic [15:0]       SW,
   output logic [15:0]       MAR,
   output logic [15:0]       MDR,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [15:0]       bram_wdata,
   output logic              bram_we,
   input  logic [15:0]       bram_rdata,
   output logic              Mem_Ready,
   output logic [15:0]       HEX_DATA
);

   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   bridge_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   word_t            mar_q;
   word_t            mdr_q;
   word_t            sw_sync;
   word_t            rdata_c;
   word_t            mdr_src_c;
   logic             io_hit_c;
   logic             rd_last_c;
   logic             we_pulse_c;
   logic             we_q;
   logic             rdy_q;

   // Switch synchronizer
   sync2 #(.W(WORD_W)) u_sw_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d_i   (SW),
      .q_o   (sw_sync)
   );

`ifdef SLC3_MMIO_EN
   word_t hex_q;

   assign io_hit_c = (mar_q == IO_ADDR);
   assign rdata_c  = io_hit_c ? sw_sync : bram_rdata;

   // Hex display latches MDR on the cycle a write to IO_ADDR is accepted
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hex_q <= '0;
      end else if ((state_q == IDLE) && Mem_WE && io_hit_c) begin
         hex_q <= mdr_q;
      end
   end

   assign HEX_DATA = hex_q;
`else
   logic unused_mmio;

   assign io_hit_c    = 1'b0;
   assign rdata_c     = bram_rdata;
   assign HEX_DATA    = '0;
   assign unused_mmio = ^{sw_sync, IO_ADDR};
`endif

   // Counter value after this RD_WAIT cycle; data is valid once it hits RD_LAT-1
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign rd_last_c = (RD_LAT <= 1) || (cnt_inc == CNT_W'(RD_LAT - 1));

   // MDR takes read data only for a pure read; any other load comes from Bus
   assign mdr_src_c = (Mem_OE && !Mem_WE) ? rdata_c : Bus;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_pulse_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (Mem_WE) begin
               state_d    = WR_DONE;
               we_pulse_c = !io_hit_c;
            end else if (Mem_OE) begin
               state_d = RD_WAIT;
               cnt_d   = '0;
            end
         end
         RD_WAIT: begin
            if (!Mem_OE) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (rd_last_c) begin
                  state_d = RD_DONE;
               end
            end
         end
         RD_DONE: begin
            if (!Mem_OE) begin
               state_d = IDLE;
            end
         end
         WR_DONE: begin
            if (!Mem_WE) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         we_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_pulse_c;
         rdy_q   <= (state_d == RD_DONE) || (state_d == WR_DONE);
         if (LD_MAR) begin
            mar_q <= Bus;
         end
         if (LD_MDR) begin
            mdr_q <= mdr_src_c;
         end
      end
   end

   assign MAR        = mar_q;
   assign MDR        = mdr_q;
   assign bram_addr  = ADDR_W'(mar_q);
   assign bram_wdata = mdr_q;
   assign bram_we    = we_q;
   assign Mem_Ready  = rdy_q;

endmodule
